// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and hands each
// fetched word with its PC to decode through a valid/ready output register.
module instruction_fetch_unit #(
  parameter int unsigned SIZE       = 128,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [32:0] PC_LIMIT = 33'(SIZE) * 33'd4;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic [31:0] fetch_count_q;
  logic        out_valid_q;
  logic        halted_q;
  logic        misalign_q;

  logic        load_en_s;
  logic [32:0] pc_inc_s;
  logic [31:0] pc_seq_d;

  // Load condition and sequential next PC; the 33-bit sum keeps the wrap compare exact
  always_comb begin
    load_en_s = (state_q == FETCH) && !redirect_valid && (!out_valid_q || out_ready);
    pc_inc_s  = {1'b0, pc_q} + 33'd4;
    if (pc_inc_s >= PC_LIMIT) begin
      pc_seq_d = 32'h0000_0000;
    end else begin
      pc_seq_d = pc_inc_s[31:0];
    end
  end

  // Fetch FSM, PC and IF/ID register; redirect outranks load and drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      out_instr_q   <= 32'h0000_0000;
      out_pc_q      <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
      out_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
          end
        end
        FETCH, HALTED: begin
          if (redirect_valid) begin
            state_q     <= FETCH;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            pc_q        <= {redirect_target[31:2], 2'b00};
            if (redirect_target[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
            end
          end else if (load_en_s) begin
            out_instr_q   <= imem_instr;
            out_pc_q      <= pc_q;
            out_valid_q   <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
            // The halt word is issued but the PC stays on it
            if (imem_instr == HALT_INSTR) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_seq_d;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised scoreboard bench for instruction_fetch_unit with a small memory
// and a transaction-level reference model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int unsigned SIZE_T     = 8;
  localparam int unsigned AW         = $clog2(SIZE_T);
  localparam logic [31:0] RESET_PC_T = 32'h0000_0004;
  localparam logic [31:0] HALT_T     = 32'hFFFF_FFFF;
  localparam logic [31:0] LIMIT_T    = SIZE_T * 4;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_HALTED = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  instruction_fetch_unit #(
    .SIZE(SIZE_T), .RESET_PC(RESET_PC_T), .HALT_INSTR(HALT_T)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: out-of-range addresses return word 0
  logic [31:0] mem [SIZE_T];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < LIMIT_T) return mem[a[AW+1:2]];
    return mem[0];
  endfunction
  assign imem_instr = mem_rd(imem_addr);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] cnt; } exp_t;
  exp_t exp_q[$];
  int          m_state;
  logic [31:0] m_pc, m_count, m_opc, m_oinstr;
  bit          m_valid, m_err;

  task automatic model_reset();
    m_state = M_IDLE; m_pc = RESET_PC_T; m_count = 0;
    m_opc = 0; m_oinstr = 0; m_valid = 0; m_err = 0;
    exp_q.delete();
  endtask

  // What the next clock edge does, given the inputs now applied
  task automatic model_edge();
    logic [31:0] w;
    if (m_state == M_IDLE) begin
      if (start) m_state = M_FETCH;
    end else if (redirect_valid) begin
      m_valid = 0;
      m_pc = {redirect_target[31:2], 2'b00};
      m_state = M_FETCH;
      if (redirect_target[1:0] != 2'b00) m_err = 1;
    end else if (m_state == M_FETCH && (!m_valid || out_ready)) begin
      w = mem_rd(m_pc);
      m_count = m_count + 1;
      exp_q.push_back('{pc: m_pc, instr: w, cnt: m_count});
      m_opc = m_pc; m_oinstr = w; m_valid = 1;
      if (w == HALT_T) m_state = M_HALTED;
      else m_pc = (m_pc + 4 >= LIMIT_T) ? 32'h0 : m_pc + 4;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_state();
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_state == M_HALTED});
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
    chk("fetch_count", fetch_count, m_count);
    if (m_valid) begin
      chk("held_out_pc", out_pc, m_opc);
      chk("held_out_instr", out_instr, m_oinstr);
    end
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] tg, input logic rdy);
    start = st; redirect_valid = rv; redirect_target = tg; out_ready = rdy;
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  // Monitor: every new word loaded into the output register is checked against the scoreboard
  logic [31:0] last_fc = 32'h0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      last_fc = 32'h0;
    end else if (fetch_count != last_fc) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_load: fetch_count %0d with empty scoreboard", fetch_count);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("load_count", fetch_count, e.cnt);
      end
      last_fc = fetch_count;
    end
  end

  initial begin
    logic [31:0] tg;
    for (int i = 0; i < SIZE_T; i++) mem[i] = 32'h0000_00A0 + i;
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33; mem[4] = 32'h44; mem[5] = HALT_T;
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);
    reset = 1'b0;

    // Idle ignores redirect; then start and stream four words
    step(1'b0, 1'b1, 32'h0000_0010, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Stall, resume, run into the halt word at 0x14 and sit halted
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    // Misaligned redirect out of HALTED, then run through the wrap
    step(1'b0, 1'b1, 32'h0000_000A, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect with a valid word and ready high, then to a target beyond memory
    step(1'b0, 1'b1, 32'h0000_0018, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional halt words and memory rewrites
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)
        mem[$urandom_range(0, SIZE_T - 1)] = ($urandom_range(0, 7) == 0) ? HALT_T : $urandom;
      case ($urandom_range(0, 3))
        0: tg = $urandom_range(0, LIMIT_T - 1) & 32'hFFFF_FFFC;
        1: tg = $urandom_range(0, LIMIT_T - 1);
        2: tg = $urandom;
        default: tg = LIMIT_T + ($urandom_range(0, 15) << 2);
      endcase
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, tg,
           $urandom_range(0, 9) < 7);
    end

    // Async reset in the middle of a stall
    mem[0] = 32'h1234_5678;
    step(1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("prereset_valid", {31'h0, out_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_imem_addr", imem_addr, RESET_PC_T);
    chk("async_fetch_count", fetch_count, 32'h0);
    chk("async_misalign", {31'h0, misalign_err}, 32'h0);
    chk("async_out_pc", out_pc, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_state();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    #2;

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of instruction_memory. It owns the program counter and drives the memory read address. It captures the returned instruction together with its PC into an IF/ID output register, which presents them to decode via a valid/ready handshake. It handles branch redirects, decode backpressure, PC wrap-around and halt detection.

Parameters:
SIZE, 128, instruction memory depth in words; PC wraps at SIZE*4
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch once issued

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  one-cycle pulse, IDLE -> FETCH
imem_addr  output  32  byte address to instruction_memory readAdress; equals pc register (combinational from the register)
imem_instr  input  32  instruction word returned for imem_addr, valid in the same cycle
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  new byte PC
out_valid  output  1  IF/ID register holds a valid instruction
out_ready  input  1  decode accepts out_* this cycle
out_instr  output  32  fetched instruction
out_pc  output  32  byte address of out_instr
halted  output  1  high in HALTED state
misalign_err  output  1  sticky; set when a redirect target has addr[1:0] != 0
fetch_count  output  32  number of instructions loaded into the output register since reset

Behaviour:
- Reset (async, any time incl. mid-handshake): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, misalign_err=0, fetch_count=0.
- FSM states: IDLE, FETCH, HALTED.
  - IDLE: no loads; start=1 -> FETCH at the next edge.
  - FETCH: loads as below; loading HALT_INSTR -> HALTED.
  - HALTED: pc frozen; the held output still drains via the handshake; redirect_valid -> FETCH.
- load_en = (state==FETCH) && !redirect_valid && (!out_valid || out_ready).
- On load_en at a posedge:
  - out_instr <= imem_instr; out_pc <= pc; out_valid <= 1.
  - fetch_count += 1, wrapping modulo 2^32.
  - pc <= (pc+4 >= SIZE*4) ? 0 : pc+4.
  - If imem_instr == HALT_INSTR: pc unchanged, state <= HALTED.
- Otherwise, if out_valid && out_ready: out_valid <= 0.
- Stall: out_valid=1 and out_ready=0 -> out_instr, out_pc and pc hold.
- Redirect (highest priority, in any state except IDLE; ignored in IDLE):
  - out_valid <= 0 (flush); pc <= {redirect_target[31:2], 2'b00}; state <= FETCH.
  - If redirect_target[1:0] != 0: misalign_err <= 1.
  - A simultaneous out_ready is ignored; the flushed word is considered dropped.
- Redirect target >= SIZE*4: loaded as given. instruction_memory returns word 0 for that address, and the following increment wraps pc to 0.
- start while in FETCH or HALTED: ignored.
- Latency: an instruction appears on out_* one cycle after pc addresses it. Throughput is 1 per cycle while out_ready=1.

Test Plan:
- Reset, start pulse, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_pc 0,4,8,12 with out_instr 0x11..0x44 on consecutive cycles; fetch_count=4.
- out_ready held 0 for 3 cycles after the first load -> out_instr=0x11 and out_pc=0 stable; imem_addr stays 4; resumes with 0x22 when ready rises.
- SIZE=4, continuous fetch -> out_pc sequence 0,4,8,12,0,4 (wrap).
- redirect_valid with target 0x0A while out_valid=1 -> next cycle out_valid=0, imem_addr=0x08, misalign_err=1; the cycle after, out_pc=0x08.
- Word 2 = 32'hFFFF_FFFF -> out_pc=8 carries the halt word, halted=1, imem_addr stays 8, no further loads; then redirect to 0 -> halted=0 and fetch restarts at 0.
- Assert reset mid-stall (out_valid=1, out_ready=0) -> out_valid=0, imem_addr=RESET_PC and fetch_count=0 immediately, without waiting for a clock edge.
